// File: rtl/game_master_fsm_param_if.sv
// Bundle of sprite-control, collision and timer signals between the game master FSM and the game datapath.
// Modport master is the FSM side; slave is the sprite/timer side.
interface game_master_fsm_param_if #(
    parameter int N_TARGETS = 3,
    parameter int N_LIVES   = 3,
    parameter int WIN_SCORE = 3
);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int LW = $clog2(N_LIVES + 1);

    logic                 launch_key;
    logic [N_TARGETS-1:0] target_within_screen;
    logic                 bullet_within_screen;
    logic                 spaceship_within_screen;
    logic                 collision;
    logic [N_TARGETS-1:0] collision_bullet;
    logic                 end_of_game_timer_running;

    logic [N_TARGETS-1:0] target_write_xy;
    logic [N_TARGETS-1:0] target_write_dxy;
    logic [N_TARGETS-1:0] target_enable_update;
    logic                 bullet_write_xy;
    logic                 bullet_write_dxy;
    logic                 bullet_enable_update;
    logic                 spaceship_write_xy;
    logic                 spaceship_write_dxy;
    logic                 spaceship_enable_update;
    logic [N_LIVES-1:0]   heart_write_xy;
    logic [N_LIVES-1:0]   heart_enable_update;
    logic                 end_of_game_timer_start;
    logic                 game_won;
    logic                 game_lost;
    logic [SW-1:0]        score;
    logic [LW-1:0]        n_lives;
    logic [2:0]           state_dbg;

    modport master (
        input  launch_key, target_within_screen, bullet_within_screen,
               spaceship_within_screen, collision, collision_bullet,
               end_of_game_timer_running,
        output target_write_xy, target_write_dxy, target_enable_update,
               bullet_write_xy, bullet_write_dxy, bullet_enable_update,
               spaceship_write_xy, spaceship_write_dxy, spaceship_enable_update,
               heart_write_xy, heart_enable_update, end_of_game_timer_start,
               game_won, game_lost, score, n_lives, state_dbg
    );

    modport slave (
        output launch_key, target_within_screen, bullet_within_screen,
               spaceship_within_screen, collision, collision_bullet,
               end_of_game_timer_running,
        input  target_write_xy, target_write_dxy, target_enable_update,
               bullet_write_xy, bullet_write_dxy, bullet_enable_update,
               spaceship_write_xy, spaceship_write_dxy, spaceship_enable_update,
               heart_write_xy, heart_enable_update, end_of_game_timer_start,
               game_won, game_lost, score, n_lives, state_dbg
    );
endinterface

// File: rtl/game_master_fsm_param.sv
// Game master FSM: sequences rounds, aiming/shooting, scoring, lives and the end-of-game pause.
// Define GAME_MASTER_TIME_LIMIT_EN to use the pause timer as a play-time limit during AIM/SHOOT.
module game_master_fsm_param #(
    parameter int N_TARGETS = 3,
    parameter int N_LIVES   = 3,
    parameter int WIN_SCORE = 3
) (
    input logic                     clk,
    input logic                     rst,
    game_master_fsm_param_if.master bus
);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int LW = $clog2(N_LIVES + 1);

    typedef enum logic [2:0] {
        START_GAME  = 3'd0,
        START_ROUND = 3'd1,
        AIM         = 3'd2,
        SHOOT       = 3'd3,
        END_ROUND   = 3'd4,
        END_GAME    = 3'd5,
        END_WAIT    = 3'd6
    } state_t;

    state_t               state;
    logic [N_TARGETS-1:0] alive;
    logic [SW-1:0]        score;
    logic [LW-1:0]        n_lives;
    logic [1:0]           wait_cnt;

    logic [N_TARGETS-1:0] hits;
    logic [4:0]           hit_count;
    logic [4:0]           score_sum;
    logic [SW-1:0]        score_hit;
    logic                 round_end;
    logic                 life_loss;
    logic [LW-1:0]        lives_next;
    logic [N_LIVES-1:0]   heart_mask_next;

    // Hit accounting: only targets still alive can score, and the score saturates at the winning value.
    always_comb begin
        hits      = bus.collision_bullet & alive;
        hit_count = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            hit_count = hit_count + 5'(hits[i]);
        end
        score_sum = 5'(score) + hit_count;
        score_hit = (score_sum >= 5'(WIN_SCORE)) ? SW'(WIN_SCORE) : SW'(score_sum);
        round_end = (|(alive & ~bus.target_within_screen)) || !bus.bullet_within_screen
                    || !bus.spaceship_within_screen || (alive == '0);
    end

    // Lives are resolved ahead of the FSM so the heart enables always agree with n_lives in the same cycle.
    always_comb begin
        life_loss = ((state == AIM) || (state == SHOOT)) && bus.collision;
        if (state == START_GAME) begin
            lives_next = LW'(N_LIVES);
        end else if (life_loss && (n_lives != '0)) begin
            lives_next = n_lives - LW'(1);
        end else begin
            lives_next = n_lives;
        end
        for (int i = 0; i < N_LIVES; i++) begin
            heart_mask_next[i] = (i < int'(lives_next));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= START_GAME;
            alive                       <= '1;
            score                       <= '0;
            n_lives                     <= LW'(N_LIVES);
            wait_cnt                    <= '0;
            bus.target_write_xy         <= '0;
            bus.target_write_dxy        <= '0;
            bus.target_enable_update    <= '0;
            bus.bullet_write_xy         <= 1'b0;
            bus.bullet_write_dxy        <= 1'b0;
            bus.bullet_enable_update    <= 1'b0;
            bus.spaceship_write_xy      <= 1'b0;
            bus.spaceship_write_dxy     <= 1'b0;
            bus.spaceship_enable_update <= 1'b0;
            bus.heart_write_xy          <= '0;
            bus.heart_enable_update     <= '0;
            bus.end_of_game_timer_start <= 1'b0;
            bus.game_won                <= 1'b0;
            bus.game_lost               <= 1'b0;
        end else begin
            bus.target_write_xy         <= '0;
            bus.target_write_dxy        <= '0;
            bus.target_enable_update    <= '0;
            bus.bullet_write_xy         <= 1'b0;
            bus.bullet_write_dxy        <= 1'b0;
            bus.bullet_enable_update    <= 1'b0;
            bus.spaceship_write_xy      <= 1'b0;
            bus.spaceship_write_dxy     <= 1'b0;
            bus.spaceship_enable_update <= 1'b0;
            bus.heart_write_xy          <= '0;
            bus.end_of_game_timer_start <= 1'b0;
            n_lives                     <= lives_next;
            bus.heart_enable_update     <= heart_mask_next;

            case (state)
                START_GAME: begin
                    score              <= '0;
                    alive              <= '1;
                    bus.game_won       <= 1'b0;
                    bus.game_lost      <= 1'b0;
                    bus.heart_write_xy <= '1;
`ifdef GAME_MASTER_TIME_LIMIT_EN
                    bus.end_of_game_timer_start <= 1'b1;
`endif
                    state <= START_ROUND;
                end

                START_ROUND: begin
                    bus.target_write_xy    <= alive;
                    bus.target_write_dxy   <= alive;
                    bus.bullet_write_xy    <= 1'b1;
                    bus.spaceship_write_xy <= 1'b1;
                    state                  <= AIM;
                end

                AIM: begin
                    bus.target_enable_update <= alive;
                    if (bus.collision) begin
                        state <= END_ROUND;
`ifdef GAME_MASTER_TIME_LIMIT_EN
                    end else if (!bus.end_of_game_timer_running) begin
                        bus.game_lost <= 1'b1;
                        state         <= END_GAME;
`endif
                    end else if (bus.launch_key) begin
                        state <= SHOOT;
                    end else if (round_end) begin
                        state <= END_ROUND;
                    end
                end

                SHOOT: begin
                    bus.target_enable_update    <= alive;
                    bus.bullet_write_dxy        <= 1'b1;
                    bus.bullet_enable_update    <= 1'b1;
                    bus.spaceship_write_dxy     <= 1'b1;
                    bus.spaceship_enable_update <= 1'b1;
                    // A spaceship collision wins over a simultaneous bullet hit: no score is awarded.
                    if (bus.collision) begin
                        state <= END_ROUND;
`ifdef GAME_MASTER_TIME_LIMIT_EN
                    end else if (!bus.end_of_game_timer_running) begin
                        bus.game_lost <= 1'b1;
                        state         <= END_GAME;
`endif
                    end else if (hits != '0) begin
                        score <= score_hit;
                        alive <= alive & ~hits;
                        state <= END_ROUND;
                    end else if (round_end) begin
                        state <= END_ROUND;
                    end
                end

                END_ROUND: begin
                    if (score == SW'(WIN_SCORE)) begin
                        bus.game_won <= 1'b1;
                        state        <= END_GAME;
                    end else if (n_lives == '0) begin
                        bus.game_lost <= 1'b1;
                        state         <= END_GAME;
                    end else begin
                        if (alive == '0) begin
                            alive <= '1;
                        end
                        state <= START_ROUND;
                    end
                end

                END_GAME: begin
                    bus.end_of_game_timer_start <= 1'b1;
                    wait_cnt                    <= '0;
                    state                       <= END_WAIT;
                end

                // The timer needs a couple of cycles to report busy after its start pulse, so early reads are ignored.
                END_WAIT: begin
                    if (wait_cnt != 2'd2) begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end else if (!bus.end_of_game_timer_running) begin
                        state <= START_GAME;
                    end
                end

                default: begin
                    state <= START_GAME;
                end
            endcase
        end
    end

    assign bus.score     = score;
    assign bus.n_lives   = n_lives;
    assign bus.state_dbg = state;

endmodule

// File: doc/game_master_fsm_param.md
GAME_MASTER_FSM_PARAM -- requirements
Module: game_master_fsm_param

Interface
REQ-001 SHALL have parameter N_TARGETS, default 3, number of target sprites (1..8).
REQ-002 SHALL have parameter N_LIVES, default 3, lives per game and number of heart sprites (1..7).
REQ-003 SHALL have parameter WIN_SCORE, default 3, score that wins the game (1..15); SW = $clog2(WIN_SCORE+1), LW = $clog2(N_LIVES+1).
REQ-004 SHALL have port clk  in  1  sole clock; every register changes on its rising edge only.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port launch_key  in  1  level; requests a shot while aiming.
REQ-007 SHALL have port target_within_screen  in  N_TARGETS  per-target on-screen flag.
REQ-008 SHALL have ports bullet_within_screen, spaceship_within_screen  in  1 each  on-screen flags.
REQ-009 SHALL have port collision  in  1  spaceship touched any target.
REQ-010 SHALL have port collision_bullet  in  N_TARGETS  bullet touched target i.
REQ-011 SHALL have port end_of_game_timer_running  in  1  end-of-game pause timer busy.
REQ-012 SHALL have ports target_write_xy, target_write_dxy, target_enable_update  out  N_TARGETS  per-target sprite controls.
REQ-013 SHALL have ports bullet_/spaceship_ write_xy, write_dxy, enable_update  out  1 each.
REQ-014 SHALL have ports heart_write_xy, heart_enable_update  out  N_LIVES  per-heart controls.
REQ-015 SHALL have ports end_of_game_timer_start, game_won, game_lost  out  1; score  out  SW; n_lives  out  LW; state_dbg  out  3.

Function
REQ-016 SHALL register every output; each output reflects the decision made in the previous cycle's state.
REQ-017 SHALL implement states START_GAME, START_ROUND, AIM, SHOOT, END_ROUND, END_GAME, END_WAIT; state_dbg carries the encoding 0..6 in that order.
REQ-018 START_GAME: score=0, n_lives=N_LIVES, game_won=game_lost=0, alive mask = all ones, pulse all heart_write_xy; -> START_ROUND.
REQ-019 START_ROUND: pulse write_xy and write_dxy for targets with alive bit set, write_xy for bullet and spaceship; -> AIM.
REQ-020 AIM: target_enable_update = alive mask; priority collision > launch_key > round end; collision -> lose life, -> END_ROUND; launch_key -> SHOOT.
REQ-021 SHOOT: as AIM plus bullet/spaceship write_dxy and enable_update high; priority collision > bullet hit > round end.
REQ-022 Bullet hit: score += popcount(collision_bullet & alive), saturating at WIN_SCORE; those alive bits cleared; -> END_ROUND.
REQ-023 Simultaneous collision and collision_bullet in SHOOT: only the life loss is applied.
REQ-024 Round end = any alive target off screen, or bullet or spaceship off screen, or alive mask all zero.
REQ-025 Life loss: n_lives decrements, never below 0; heart_enable_update[i] = (i < n_lives) in every state.
REQ-026 END_ROUND: score==WIN_SCORE -> game_won=1, END_GAME; n_lives==0 -> game_lost=1, END_GAME; alive mask zero -> reset mask to all ones, START_ROUND; else START_ROUND.
REQ-027 END_GAME: pulse end_of_game_timer_start for one cycle; -> END_WAIT.
REQ-028 END_WAIT: ignore end_of_game_timer_running for the first 2 cycles, then return to START_GAME on the first cycle it reads 0; game_won/game_lost held until START_GAME.

Reset
REQ-029 On rst: state=START_GAME, score=0, n_lives=N_LIVES, alive mask all ones, all other outputs 0.
REQ-030 rst asserted in any state, including mid-SHOOT or END_WAIT, SHALL override all pending transitions that cycle.

Configuration
REQ-031 With GAME_MASTER_TIME_LIMIT_EN defined, the timer is started in START_GAME, and end_of_game_timer_running==0 in AIM or SHOOT sets game_lost=1 and goes to END_GAME, with priority below collision.
REQ-032 Without GAME_MASTER_TIME_LIMIT_EN, the timer is started only in END_GAME and is ignored in AIM and SHOOT.

Verification
REQ-033 Reset, then idle 3 cycles with all inputs 0 -> state_dbg 0,1,2; heart_write_xy=3'b111 pulsed once; n_lives=3; score=0.
REQ-034 In SHOOT, collision_bullet=3'b101 for one cycle -> score=2; target_enable_update=3'b010 in the next AIM state.
REQ-035 Three separate single collisions -> n_lives 2,1,0; heart_enable_update 3'b011, 3'b001, 3'b000; game_lost=1; end_of_game_timer_start pulses once.
REQ-036 collision and collision_bullet=3'b001 in the same SHOOT cycle -> n_lives decrements; score unchanged.
REQ-037 Reach score 3 -> game_won=1; hold end_of_game_timer_running=1 for 10 cycles -> state remains END_WAIT; drop it to 0 -> START_GAME next cycle.
REQ-038 With GAME_MASTER_TIME_LIMIT_EN defined, drive end_of_game_timer_running=0 in AIM -> game_lost=1 and state END_GAME.
